// File: rtl/adder_measure_pkg.sv
// adder_measure_pkg: shared types and default constants for the adder
// measurement sequencer (state encoding, default window lengths and the
// helper that sizes the window timer).
package adder_measure_pkg;

    localparam int DEFAULT_WIDTH         = 32;
    localparam int DEFAULT_RUN_CYCLES    = 1000;
    localparam int DEFAULT_SETTLE_CYCLES = 2;
    localparam int DEFAULT_TIMER_W       = $clog2(DEFAULT_RUN_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_SETTLE,
        ST_CAPTURE,
        ST_RESPOND
    } meas_state_t;

    // The same timer serves both RUN and SETTLE, so it must hold the longer one.
    function automatic int timer_width(input int run_cycles, input int settle_cycles);
        int longest;
        longest = (run_cycles > settle_cycles) ? run_cycles : settle_cycles;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/adder_measure_seq_if.sv
// adder_measure_seq_if: command/response bus between the LA register bank
// (master) and the measurement sequencer (slave).
interface adder_measure_seq_if #(
    parameter int WIDTH = 32
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_sum;
    logic [WIDTH-1:0] rsp_count;
    logic             rsp_sat;
    logic             rsp_err;

    modport master (
        output cmd_valid, cmd_a, cmd_b, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_sum, rsp_count, rsp_sat, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, rsp_ready,
        output cmd_ready, rsp_valid, rsp_sum, rsp_count, rsp_sat, rsp_err
    );
endinterface

// File: rtl/adder_measure_seq_timer.sv
// meas_window_timer: loadable down-counter that flags the last cycle of a
// window. Loading N makes done high on the N-th cycle after the load.
module meas_window_timer #(
    parameter int CNT_W = 10
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic             done
);
    logic [CNT_W-1:0] count;

    // Reload on request, otherwise count down and park at zero.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == CNT_W'(1));
endmodule

// File: rtl/adder_measure_seq.sv
// adder_measure_seq: loads an operand pair into the instrumented adder,
// clears and runs its ring-oscillator counter for a fixed window, lets the
// count settle, then returns sum and count as one response.
// Optional feature: define MEASURE_CHECK_EN to build the sum comparator
// that drives rsp_err; otherwise rsp_err is tied low.
module adder_measure_seq
    import adder_measure_pkg::*;
#(
    parameter int WIDTH         = DEFAULT_WIDTH,
    parameter int RUN_CYCLES    = DEFAULT_RUN_CYCLES,
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 active,
    input  logic                 abort,
    adder_measure_seq_if.slave   bus,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    output logic                 ctr_clear,
    output logic                 run_en,
    input  logic [WIDTH-1:0]     add_s,
    input  logic [WIDTH-1:0]     add_count
);
    localparam int CNT_W = timer_width(RUN_CYCLES, SETTLE_CYCLES);

    meas_state_t      state;
    meas_state_t      state_next;
    logic             accept;
    logic             timer_load;
    logic [CNT_W-1:0] timer_value;
    logic             timer_done;
    logic             rsp_valid_q;
    logic [WIDTH-1:0] rsp_sum_q;
    logic [WIDTH-1:0] rsp_count_q;
    logic             rsp_sat_q;

    assign bus.cmd_ready = (state == ST_IDLE) & active & ~wb_rst_i;
    assign accept        = bus.cmd_valid & bus.cmd_ready;

    meas_window_timer #(.CNT_W(CNT_W)) u_timer (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .load       (timer_load),
        .load_value (timer_value),
        .done       (timer_done)
    );

    // Next-state logic; dropping active wins over abort, which wins over progress.
    always_comb begin
        state_next  = state;
        timer_load  = 1'b0;
        timer_value = CNT_W'(RUN_CYCLES);
        if (!active) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) state_next = ST_LOAD;
                end
                ST_LOAD: begin
                    timer_load  = 1'b1;
                    timer_value = CNT_W'(RUN_CYCLES);
                    state_next  = abort ? ST_IDLE : ST_RUN;
                end
                ST_RUN: begin
                    if (abort) begin
                        state_next = ST_IDLE;
                    end else if (timer_done) begin
                        timer_load  = 1'b1;
                        timer_value = CNT_W'(SETTLE_CYCLES);
                        state_next  = ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (abort) begin
                        state_next = ST_IDLE;
                    end else if (timer_done) begin
                        state_next = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    state_next = abort ? ST_IDLE : ST_RESPOND;
                end
                ST_RESPOND: begin
                    if (bus.rsp_ready) state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state <= ST_IDLE;
        else          state <= state_next;
    end

    // Strobes are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ctr_clear   <= 1'b0;
            run_en      <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            ctr_clear   <= (state_next == ST_LOAD);
            run_en      <= (state_next == ST_RUN);
            rsp_valid_q <= (state_next == ST_RESPOND);
        end
    end

    // Operands are latched on command accept and held until the next one.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            add_a <= '0;
            add_b <= '0;
        end else if (accept) begin
            add_a <= bus.cmd_a;
            add_b <= bus.cmd_b;
        end
    end

    // Capture the settled adder outputs only when a response will actually be issued.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rsp_sum_q   <= '0;
            rsp_count_q <= '0;
            rsp_sat_q   <= 1'b0;
        end else if ((state == ST_CAPTURE) && (state_next == ST_RESPOND)) begin
            rsp_sum_q   <= add_s;
            rsp_count_q <= add_count;
            rsp_sat_q   <= &add_count;
        end
    end

`ifdef MEASURE_CHECK_EN
    logic             rsp_err_q;
    logic [WIDTH-1:0] expected_sum;

    assign expected_sum = add_a + add_b;

    // Flag a mismatch between the adder result and the modular sum of the latched operands.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rsp_err_q <= 1'b0;
        end else if ((state == ST_CAPTURE) && (state_next == ST_RESPOND)) begin
            rsp_err_q <= (add_s != expected_sum);
        end
    end

    assign bus.rsp_err = rsp_err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.rsp_count = rsp_count_q;
    assign bus.rsp_sat   = rsp_sat_q;
endmodule
